// File: rtl/reg_wr_arb.sv
// Round-robin arbiter that grants N requesters write access to one shared
// W-bit register. Every write is a two-cycle GRANT/WRITE sequence.
module reg_wr_arb #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] d,
    input  logic           clr,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           q_vld,
    output logic [2:0]     q_src,
    output logic [1:0]     fsm_state
);

    // Handshake: a requester raises req[i] (level) with d slice i stable and
    // holds both until it sees ack[i]. gnt[i] marks the cycle in which the
    // write is pending; ack[i] pulses for one cycle after q has been loaded.
    // Dropping req[i] while gnt[i] is high aborts the write without an ack.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [2:0]     last, last_nxt;
    logic [2:0]     win, win_nxt;
    logic [N-1:0]   gnt_nxt, ack_nxt;
    logic [W-1:0]   q_nxt;
    logic           q_vld_nxt;
    logic [2:0]     q_src_nxt;

    logic [N-1:0]   arb_req;
    logic [N-1:0]   rot;
    logic           arb_hit;
    logic [2:0]     arb_idx;
    logic [W-1:0]   wr_data;

    assign fsm_state = state;

    // Rotate the request vector so bit 0 is the index right after the last
    // grant; the first set bit of the rotated vector is the winner.
    always_comb begin
        arb_req = (state == WRITE) ? (req & ~ack) : req;
        rot     = N'({arb_req, arb_req} >> (32'(last) + 32'd1));
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!arb_hit && rot[k]) begin
                arb_hit = 1'b1;
                arb_idx = 3'((32'(last) + 32'd1 + 32'(k)) % N);
            end
        end
    end

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                wr_data = d[k*W +: W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        q_nxt     = q;
        q_vld_nxt = q_vld;
        q_src_nxt = q_src;
        last_nxt  = last;
        win_nxt   = win;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    gnt_nxt   = ONE << arb_idx;
                    win_nxt   = arb_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // last advances even on abort so a vanished requester
                // cannot keep its priority.
                last_nxt = win;
                if (|(req & gnt)) begin
                    q_nxt     = wr_data;
                    q_vld_nxt = 1'b1;
                    q_src_nxt = win;
                    ack_nxt   = gnt;
                    state_nxt = WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (arb_hit) begin
                    gnt_nxt   = ONE << arb_idx;
                    win_nxt   = arb_idx;
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (clr) begin
            q_nxt     = '0;
            q_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= '0;
            q     <= '0;
            q_vld <= 1'b0;
            q_src <= '0;
            last  <= 3'(N - 1);
            win   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
            q     <= q_nxt;
            q_vld <= q_vld_nxt;
            q_src <= q_src_nxt;
            last  <= last_nxt;
            win   <= win_nxt;
        end
    end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed bench for reg_wr_arb: expected writes are queued when granted and
// checked against q/q_src/q_vld whenever an ack pulse appears.
module tb_reg_wr_arb;

    localparam int W = 8;
    localparam int N = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic           clr;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           q_vld;
    logic [2:0]     q_src;
    logic [1:0]     fsm_state;

    int errors = 0;
    int checks = 0;

    // {src[2:0], vld, data[W-1:0]}
    logic [W+3:0] exp_q[$];
    logic [W+3:0] exp_e;

    reg_wr_arb #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d         (d),
        .clr       (clr),
        .gnt       (gnt),
        .ack       (ack),
        .q         (q),
        .q_vld     (q_vld),
        .q_src     (q_src),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_write(input logic [2:0] src, input logic vld, input logic [W-1:0] data);
        exp_q.push_back({src, vld, data});
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(|gnt && |ack) && $onehot0(gnt) && $onehot0(ack)) else begin
                errors++;
                $error("FAIL exclusive: gnt=%b ack=%b expected at most one bit, never both", gnt, ack);
            end
            if (|ack) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack: ack=%b expected no ack", ack);
                end
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    checks++;
                    assert ({q_src, q_vld, q} === exp_e) else begin
                        errors++;
                        $error("FAIL write_data: src/vld/q=%0h/%0b/%0h expected %0h/%0b/%0h",
                               q_src, q_vld, q, exp_e[W+3:W+1], exp_e[W], exp_e[W-1:0]);
                    end
                    checks++;
                    assert (ack === (4'b0001 << exp_e[W+3:W+1])) else begin
                        errors++;
                        $error("FAIL ack_owner: ack=%b expected bit %0d", ack, exp_e[W+3:W+1]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        d     = '0;
        clr   = 1'b0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_q_vld", 32'(q_vld), 32'h0);
        check("rst_q_src", 32'(q_src), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(S_IDLE));
        rst_n = 1'b1;
        step();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single write from requester 0.
        req = 4'b0001;
        d[7:0] = 8'hA5;
        step();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_ack_low", 32'(ack), 32'h0);
        check("t1_state", 32'(fsm_state), 32'(S_GRANT));
        push_write(3'd0, 1'b1, 8'hA5);
        step();
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_gnt_low", 32'(gnt), 32'h0);
        req = '0;
        step();
        check("t1_ack_once", 32'(ack), 32'h0);
        check("t1_idle", 32'(fsm_state), 32'(S_IDLE));
        check("t1_q_hold", 32'(q), 32'hA5);

        // Round-robin over all four, twice, starting fresh from reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        step();
        for (int r = 0; r < 2; r++) begin
            req = 4'b1111;
            for (int i = 0; i < N; i++) begin
                step();
                check($sformatf("rr%0d_gnt%0d", r, i), 32'(gnt), 32'(1) << i);
                push_write(3'(i), 1'b1, d[i*W +: W]);
                step();
                check($sformatf("rr%0d_ack%0d", r, i), 32'(ack), 32'(1) << i);
                req[i] = 1'b0;
            end
            step();
            check($sformatf("rr%0d_idle", r), 32'(fsm_state), 32'(S_IDLE));
        end

        // Two requesters back to back, no idle cycle in between.
        d[7:0]  = 8'h11;
        d[15:8] = 8'h22;
        req = 4'b0011;
        step();
        check("t3_gnt0", 32'(gnt), 32'h1);
        push_write(3'd0, 1'b1, 8'h11);
        step();
        check("t3_ack0", 32'(ack), 32'h1);
        req[0] = 1'b0;
        step();
        check("t3_gnt1", 32'(gnt), 32'h2);
        check("t3_no_idle", 32'(fsm_state), 32'(S_GRANT));
        push_write(3'd1, 1'b1, 8'h22);
        step();
        check("t3_ack1", 32'(ack), 32'h2);
        req = '0;
        step();
        check("t3_idle", 32'(fsm_state), 32'(S_IDLE));

        // Requester 2 withdraws during GRANT.
        d[23:16] = 8'h77;
        req = 4'b0100;
        step();
        check("t4_gnt2", 32'(gnt), 32'h4);
        req = '0;
        step();
        check("t4_gnt_clr", 32'(gnt), 32'h0);
        check("t4_no_ack", 32'(ack), 32'h0);
        check("t4_idle", 32'(fsm_state), 32'(S_IDLE));
        check("t4_q_keep", 32'(q), 32'h22);

        // Clear while idle: q_src keeps the last writer.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_q", 32'(q), 32'h0);
        check("clr_q_vld", 32'(q_vld), 32'h0);
        check("clr_q_src", 32'(q_src), 32'h1);
        check("clr_state", 32'(fsm_state), 32'(S_IDLE));

        // After the abort at 2, search starts at 3 even with 0 requesting.
        d[31:24] = 8'h33;
        d[7:0]   = 8'h44;
        req = 4'b1001;
        step();
        check("t4_gnt3", 32'(gnt), 32'h8);
        push_write(3'd3, 1'b1, 8'h33);
        step();
        check("t4_ack3", 32'(ack), 32'h8);
        req[3] = 1'b0;
        step();
        check("t4_gnt0_wrap", 32'(gnt), 32'h1);
        push_write(3'd0, 1'b1, 8'h44);
        step();
        check("t4_ack0", 32'(ack), 32'h1);
        req = '0;
        step();

        // Clear coincident with the write edge of requester 3.
        d[31:24] = 8'h5A;
        req = 4'b1000;
        step();
        check("t5_gnt3", 32'(gnt), 32'h8);
        clr = 1'b1;
        push_write(3'd3, 1'b0, 8'h00);
        step();
        check("t5_ack3", 32'(ack), 32'h8);
        clr = 1'b0;
        req = '0;
        step();
        check("t5_q", 32'(q), 32'h0);
        check("t5_q_src", 32'(q_src), 32'h3);

        // Asynchronous reset while a grant is pending.
        d[7:0] = 8'hC3;
        req = 4'b0001;
        step();
        check("t6_gnt0", 32'(gnt), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_gnt", 32'(gnt), 32'h0);
        check("t6_async_ack", 32'(ack), 32'h0);
        check("t6_async_q_src", 32'(q_src), 32'h0);
        check("t6_async_state", 32'(fsm_state), 32'(S_IDLE));
        step();
        rst_n = 1'b1;
        req = '0;
        step();
        check("t6_no_ack", 32'(ack), 32'h0);
        req = 4'b0001;
        step();
        check("t6_regnt", 32'(gnt), 32'h1);
        push_write(3'd0, 1'b1, 8'hC3);
        step();
        check("t6_reack", 32'(ack), 32'h1);
        req = '0;
        step();
        step();
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
